// File: rtl/cache_pkg.sv
// Shared cache-subsystem types and default geometry used by the fill controller
// and the cache modules it pairs with.
package cache_pkg;

    localparam int unsigned DEF_SIZE_BLOCK = 32;
    localparam int unsigned DEF_BIT_TOTAL  = 24;
    localparam int unsigned DEF_BIT_INDEX  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_FILL,
        ST_RESP
    } cache_fill_state_t;

endpackage

// File: rtl/cache_fill_ctrl.sv
// Read-miss controller: probes the cache, fetches missing blocks over an Avalon-MM
// pipelined read master, fills the cache and returns the block to the client.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter  int unsigned SIZE_BLOCK = DEF_SIZE_BLOCK,
    parameter  int unsigned BIT_TOTAL  = DEF_BIT_TOTAL,
    localparam int unsigned BIT_OFF    = $clog2(SIZE_BLOCK / 8),
    localparam int unsigned BIT_MEM    = BIT_TOTAL + BIT_OFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [BIT_TOTAL-1:0]  i_req_addr,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [SIZE_BLOCK-1:0] o_resp_data,
    output logic                  o_cache_en,
    output logic                  o_cache_wrt,
    output logic [BIT_TOTAL-1:0]  o_cache_addr,
    output logic [SIZE_BLOCK-1:0] o_cache_data,
    input  logic [SIZE_BLOCK-1:0] i_cache_data,
    input  logic                  i_cache_success,
    output logic                  o_mem_read,
    output logic [BIT_MEM-1:0]    o_mem_addr,
    input  logic                  i_mem_waitrequest,
    input  logic [SIZE_BLOCK-1:0] i_mem_readdata,
    input  logic                  i_mem_readdatavalid,
    output logic [31:0]           o_hit_cnt,
    output logic [31:0]           o_miss_cnt
);

    cache_fill_state_t       state_q, state_d;
    logic [BIT_TOTAL-1:0]    addr_q, addr_d;
    logic [SIZE_BLOCK-1:0]   data_q, data_d;
    logic [31:0]             hit_cnt_q, hit_cnt_d;
    logic [31:0]             miss_cnt_q, miss_cnt_d;
    logic                    req_ready_q, resp_valid_q;
    logic                    cache_en_q, cache_wrt_q, mem_read_q;

    // Next-state and datapath updates; cache and memory responses only matter in their own states
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK: begin
                if (i_cache_success) begin
                    data_d    = i_cache_data;
                    hit_cnt_d = hit_cnt_q + 32'd1;
                    state_d   = ST_RESP;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (!i_mem_waitrequest) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (i_mem_readdatavalid) begin
                    data_d  = i_mem_readdata;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: state_d = ST_RESP;
            ST_RESP: begin
                if (i_resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            cache_en_q   <= 1'b0;
            cache_wrt_q  <= 1'b0;
            mem_read_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
            cache_en_q   <= (state_d == ST_LOOKUP) || (state_d == ST_FILL);
            cache_wrt_q  <= (state_d == ST_FILL);
            mem_read_q   <= (state_d == ST_MEM_REQ);
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_data  = data_q;
    assign o_cache_en   = cache_en_q;
    assign o_cache_wrt  = cache_wrt_q;
    assign o_cache_addr = addr_q;
    assign o_cache_data = data_q;
    assign o_mem_read   = mem_read_q;
    assign o_mem_addr   = BIT_MEM'(addr_q) << BIT_OFF;
    assign o_hit_cnt    = hit_cnt_q;
    assign o_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl with behavioural cache and Avalon memory models.
module tb_cache_fill_ctrl;

    localparam int unsigned SB = 32;
    localparam int unsigned BT = 24;
    localparam int unsigned BM = 26;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [BT-1:0] i_req_addr = '0;
    logic          o_resp_valid;
    logic          i_resp_ready = 1'b1;
    logic [SB-1:0] o_resp_data;
    logic          o_cache_en, o_cache_wrt;
    logic [BT-1:0] o_cache_addr;
    logic [SB-1:0] o_cache_data;
    logic [SB-1:0] c_data = '0;
    logic          c_succ = 1'b0;
    logic          o_mem_read;
    logic [BM-1:0] o_mem_addr;
    logic          mem_wait;
    logic [SB-1:0] mem_rdata = '0;
    logic          mem_rdv = 1'b0;
    logic [31:0]   o_hit_cnt, o_miss_cnt;

    cache_fill_ctrl #(.SIZE_BLOCK(SB), .BIT_TOTAL(BT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_data(o_resp_data),
        .o_cache_en(o_cache_en), .o_cache_wrt(o_cache_wrt), .o_cache_addr(o_cache_addr),
        .o_cache_data(o_cache_data), .i_cache_data(c_data), .i_cache_success(c_succ),
        .o_mem_read(o_mem_read), .o_mem_addr(o_mem_addr), .i_mem_waitrequest(mem_wait),
        .i_mem_readdata(mem_rdata), .i_mem_readdatavalid(mem_rdv),
        .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        int          lat;
        logic [31:0] hit;
        logic [31:0] miss;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    logic [BM-1:0] mq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_cfg = 0, lat_cfg = 1, bp_cfg = 0;
    int          stall_cnt = 0, lat_left = 0, mem_accepts = 0;
    logic        pending = 1'b0;
    logic [BT-1:0] rd_blk = '0;
    logic        hs_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(posedge i_clk) hs_prev <= !i_rst && o_resp_valid && i_resp_ready;

    // Cache model: registered read result, fills always succeed, reset empties it
    logic [SB-1:0] cmem [logic [BT-1:0]];
    initial forever begin
        @(posedge i_clk);
        if (i_rst) begin
            cmem.delete();
            c_succ <= 1'b0;
        end else if (o_cache_en && o_cache_wrt) begin
            cmem[o_cache_addr] = o_cache_data;
            c_succ <= 1'b1;
            c_data <= o_cache_data;
        end else if (o_cache_en && cmem.exists(o_cache_addr)) begin
            c_succ <= 1'b1;
            c_data <= cmem[o_cache_addr];
        end else begin
            c_succ <= 1'b0;
            c_data <= '0;
        end
    end

    // Memory model: wr_cfg stall edges, then data lat_cfg cycles into MEM_WAIT
    assign mem_wait = o_mem_read && (stall_cnt < wr_cfg);

    always @(posedge i_clk) begin
        mem_rdv <= 1'b0;
        if (i_rst) begin
            stall_cnt <= 0;
            pending   <= 1'b0;
        end else begin
            if (o_mem_read && mem_wait) begin
                stall_cnt <= stall_cnt + 1;
                if (mq.size() > 0) check("mem_addr_stall", 32'(o_mem_addr), 32'(mq[0]));
            end else begin
                stall_cnt <= 0;
            end
            if (o_mem_read && !mem_wait) begin
                mem_accepts <= mem_accepts + 1;
                if (mq.size() == 0) check("unexpected_mem_read", 32'(o_mem_read), 32'd0);
                else check("mem_addr", 32'(o_mem_addr), 32'(mq.pop_front()));
                if (lat_cfg <= 1) begin
                    mem_rdv   <= 1'b1;
                    mem_rdata <= 32'hA500_0000 | 32'(o_mem_addr[BM-1:2]);
                end else begin
                    pending  <= 1'b1;
                    lat_left <= lat_cfg - 2;
                    rd_blk   <= o_mem_addr[BM-1:2];
                end
            end else if (pending) begin
                if (lat_left == 0) begin
                    mem_rdv   <= 1'b1;
                    mem_rdata <= 32'hA500_0000 | 32'(rd_blk);
                    pending   <= 1'b0;
                end else begin
                    lat_left <= lat_left - 1;
                end
            end
        end
    end

    // Client response-ready driver: hold ready low for bp_cfg cycles of each response
    initial begin
        int  bp_left;
        logic active;
        bp_left = 0;
        active  = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_resp_valid && !active) begin
                active  = 1'b1;
                bp_left = bp_cfg;
            end
            if (!o_resp_valid) active = 1'b0;
            if (bp_left > 0) begin
                i_resp_ready = 1'b0;
                bp_left--;
            end else begin
                i_resp_ready = 1'b1;
            end
        end
    end

    // Response monitor: pop expectation on each new response, check hold and release
    initial begin
        logic        last_vld;
        logic [31:0] held;
        exp_t        e;
        last_vld = 1'b0;
        held     = '0;
        forever begin
            @(negedge i_clk);
            if (o_resp_valid && !last_vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(o_resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", o_resp_data, e.data);
                    check("resp_latency", 32'(cyc - e.t0), 32'(e.lat));
                    check("hit_cnt", o_hit_cnt, e.hit);
                    check("miss_cnt", o_miss_cnt, e.miss);
                end
                held = o_resp_data;
            end else if (o_resp_valid) begin
                check("resp_data_hold", o_resp_data, held);
                check("req_ready_low", 32'(o_req_ready), 32'd0);
            end
            if (hs_prev) begin
                check("valid_drop_after_hs", 32'(o_resp_valid), 32'd0);
                check("req_ready_after_hs", 32'(o_req_ready), 32'd1);
            end
            last_vld = o_resp_valid;
        end
    end

    task automatic issue(input logic [BT-1:0] a, input bit miss, input int wr, input int lat,
                         input int bp, input int exp_lat, input logic [31:0] eh,
                         input logic [31:0] em, input bit track);
        int n;
        n = 0;
        @(posedge i_clk); #1;
        while (!o_req_ready && n < 300) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_req_ready) begin
            check("req_ready_timeout", 32'(o_req_ready), 32'd1);
            return;
        end
        wr_cfg  = wr;
        lat_cfg = lat;
        bp_cfg  = bp;
        if (miss) mq.push_back(BM'({a, 2'b00}));
        if (track) sb.push_back('{data: 32'hA500_0000 | 32'(a), lat: exp_lat,
                                  hit: eh, miss: em, t0: cyc});
        i_req_valid = 1'b1;
        i_req_addr  = a;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb.size() == 0 && mq.size() == 0 && o_req_ready) && n < 300) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (n >= 300) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n, acc0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rst_resp_data", o_resp_data, 32'd0);
        check("rst_cache_en", 32'(o_cache_en), 32'd0);
        check("rst_cache_wrt", 32'(o_cache_wrt), 32'd0);
        check("rst_mem_read", 32'(o_mem_read), 32'd0);
        check("rst_hit_cnt", o_hit_cnt, 32'd0);
        check("rst_miss_cnt", o_miss_cnt, 32'd0);

        // addr           miss wr lat bp lat hit miss track
        issue(24'h000123, 1, 0, 1, 0,  6,  0, 1, 1);
        wait_idle();
        issue(24'h000123, 0, 0, 1, 0,  3,  1, 1, 1);
        wait_idle();
        issue(24'h010023, 1, 3, 5, 0, 13,  1, 2, 1);
        wait_idle();
        issue(24'h000123, 0, 0, 1, 10, 3,  2, 2, 1);
        wait_idle();
        issue(24'h0000FF, 1, 0, 1, 0,  6,  2, 3, 1);
        issue(24'h0000FF, 0, 0, 1, 0,  3,  3, 3, 1);
        issue(24'h010023, 0, 0, 1, 0,  3,  4, 3, 1);
        wait_idle();

        // Reset while the fetch is outstanding in MEM_WAIT
        acc0 = mem_accepts;
        issue(24'h000777, 1, 0, 20, 0, 0, 0, 0, 0);
        n = 0;
        while (mem_accepts == acc0 && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("mem_accept_seen", 32'(mem_accepts - acc0), 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("midrst_req_ready", 32'(o_req_ready), 32'd1);
        check("midrst_mem_read", 32'(o_mem_read), 32'd0);
        check("midrst_resp_valid", 32'(o_resp_valid), 32'd0);
        check("midrst_hit_cnt", o_hit_cnt, 32'd0);
        check("midrst_miss_cnt", o_miss_cnt, 32'd0);

        issue(24'h000123, 1, 0, 1, 0,  6,  0, 1, 1);
        wait_idle();

        // Miss counter wrap
        @(posedge i_clk); #1;
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.miss_cnt_q;
        issue(24'h000200, 1, 0, 1, 0,  6,  0, 0, 1);
        wait_idle();
        issue(24'h000200, 0, 0, 1, 0,  3,  1, 0, 1);
        wait_idle();
        repeat (3) @(posedge i_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
